// File: rtl/data_mem_responder.sv
// Data-memory slave for the micro's memory stage: one read or write at a time over
// a req/ack handshake, serviced from a DEPTH x 8 register array after WAIT_CYCLES wait states.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       mem_req,
    input  logic       mem_we,
    input  logic [7:0] mem_addr,
    input  logic [7:0] mem_data_i,
    output logic [7:0] mem_data_o,
    output logic       mem_ack,
    output logic       mem_err,
    output logic       free
);

    // Handshake: a request (mem_req with mem_we/mem_addr/mem_data_i) is taken at a
    // rising edge only while free=1; completion is a single-cycle mem_ack, with
    // mem_err alongside it for an out-of-range address. Inputs are ignored while busy.

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]  DEPTH_W = 9'(DEPTH);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("data_mem_responder: WAIT_CYCLES must be 0..15");
    end
    if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
        $error("data_mem_responder: DEPTH must be 1..256");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            lat_we;
    logic [7:0]      lat_addr;
    logic [7:0]      lat_data;
    logic [7:0]      mem [DEPTH];
    logic            in_range;
    logic [IW-1:0]   idx;

    // Full 8-bit address is compared, so addresses >= DEPTH never alias.
    assign in_range = ({1'b0, lat_addr} < DEPTH_W);
    assign idx      = lat_addr[IW-1:0];
    assign free     = (state == ST_IDLE);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 8'h00;
            lat_data   <= 8'h00;
            mem_data_o <= 8'h00;
            mem_ack    <= 1'b0;
            mem_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            mem_ack <= 1'b0;
            mem_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        lat_we   <= mem_we;
                        lat_addr <= mem_addr;
                        lat_data <= mem_data_i;
                        cnt      <= WAIT_L;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mem_ack <= 1'b1;
                        state   <= ST_IDLE;
                        if (in_range) begin
                            if (lat_we) begin
                                mem[idx] <= lat_data;
                            end else begin
                                mem_data_o <= mem[idx];
                            end
                        end else begin
                            mem_err <= 1'b1;
                            if (!lat_we) begin
                                mem_data_o <= 8'h00;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responder instances (different DEPTH/WAIT_CYCLES) share the
// request bus, with mem_req steered to one instance at a time; a queue holds expected results.
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       mem_req = 1'b0;
    logic       mem_we = 1'b0;
    logic [7:0] mem_addr = 8'h00;
    logic [7:0] mem_data_i = 8'h00;
    int         sel = 0;

    logic [2:0] req_v;
    logic [2:0] ack_v;
    logic [2:0] err_v;
    logic [2:0] free_v;
    logic [7:0] dout_v [3];

    logic       ack_s, err_s, free_s;
    logic [7:0] dout_s;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q [$];
    logic [7:0] model_mem [3][256];
    logic [7:0] last_rd [3];
    int depth_of [3] = '{256, 256, 128};
    int wait_of  [3] = '{1, 0, 3};

    always #5 clk = ~clk;

    assign req_v[0] = mem_req && (sel == 0);
    assign req_v[1] = mem_req && (sel == 1);
    assign req_v[2] = mem_req && (sel == 2);
    assign ack_s    = ack_v[sel];
    assign err_s    = err_v[sel];
    assign free_s   = free_v[sel];
    assign dout_s   = dout_v[sel];

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .arst(arst), .mem_req(req_v[0]), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(dout_v[0]), .mem_ack(ack_v[0]),
        .mem_err(err_v[0]), .free(free_v[0]));

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .arst(arst), .mem_req(req_v[1]), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(dout_v[1]), .mem_ack(ack_v[1]),
        .mem_err(err_v[1]), .free(free_v[1]));

    data_mem_responder #(.DEPTH(128), .WAIT_CYCLES(3)) dut_c (
        .clk(clk), .arst(arst), .mem_req(req_v[2]), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(dout_v[2]), .mem_ack(ack_v[2]),
        .mem_err(err_v[2]), .free(free_v[2]));

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            last_rd[s] = 8'h00;
            for (int a = 0; a < 256; a++) model_mem[s][a] = 8'h00;
        end
    endtask

    // Returns {err, expected mem_data_o} and updates the reference memory.
    function automatic logic [8:0] model_access(input int s, input logic we,
                                                input logic [7:0] a, input logic [7:0] d);
        if (int'(a) >= depth_of[s]) begin
            if (!we) last_rd[s] = 8'h00;
            return {1'b1, last_rd[s]};
        end
        if (we) model_mem[s][a] = d;
        else    last_rd[s] = model_mem[s][a];
        return {1'b0, last_rd[s]};
    endfunction

    task automatic check_ack_payload(input string name);
        logic [8:0] e;
        e = exp_q.pop_front();
        checks++;
        if (err_s !== e[8]) begin
            errors++;
            $display("FAIL %s err: got %0b want %0b", name, err_s, e[8]);
        end
        checks++;
        if (dout_s !== e[7:0]) begin
            errors++;
            $display("FAIL %s data: got %02h want %02h", name, dout_s, e[7:0]);
        end
    endtask

    task automatic do_access(input int s, input logic we, input logic [7:0] a,
                             input logic [7:0] d, input string name);
        int k;
        sel = s;
        k = 0;
        while (free_s !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        @(negedge clk);
        mem_we = we; mem_addr = a; mem_data_i = d; mem_req = 1'b1;
        exp_q.push_back(model_access(s, we, a, d));
        @(posedge clk); #1;
        mem_req = 1'b0;
        k = 0;
        while (ack_s !== 1'b1 && k < 40) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (ack_s !== 1'b1 || k != wait_of[s] + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges (ack=%b) want %0d", name, k, ack_s, wait_of[s] + 1);
        end
        if (ack_s === 1'b1) begin
            check_ack_payload(name);
            checks++;
            if (free_s !== 1'b1) begin
                errors++;
                $display("FAIL %s free_with_ack: got %b want 1", name, free_s);
            end
        end else begin
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        checks++;
        if (ack_s !== 1'b0 || err_s !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: ack=%b err=%b want 0 0", name, ack_s, err_s);
        end
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (ack_s !== 1'b0 || err_s !== 1'b0 || free_s !== 1'b1 || dout_s !== 8'h00) begin
                errors++;
                $display("FAIL reset_state[%0d]: ack=%b err=%b free=%b data=%02h want 0 0 1 00",
                         s, ack_s, err_s, free_s, dout_s);
            end
        end
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        sel = 0;
        @(negedge clk);
        mem_we = 1'b1; mem_addr = 8'h10; mem_data_i = 8'hA5; mem_req = 1'b1;
        @(posedge clk); #1;
        mem_req = 1'b0;
        checks++;
        if (free_s !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid busy: free=%b want 0", free_s);
        end
        #1 arst = 1'b1;
        #1;
        checks++;
        if (free_s !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid free_async: free=%b want 1", free_s);
        end
        model_reset();
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack_s !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid no_ack: ack=%b want 0 (cycle %0d)", ack_s, i);
            end
        end
        do_access(0, 1'b0, 8'h10, 8'h00, "rst_mid_readback");
    endtask

    task automatic test_write_read();
        do_access(0, 1'b1, 8'h20, 8'h3C, "wr_20");
        do_access(0, 1'b0, 8'h20, 8'h00, "rd_20");
    endtask

    task automatic test_back_to_back();
        int idx;
        do_access(1, 1'b1, 8'h00, 8'h11, "b2b_wr0");
        do_access(1, 1'b1, 8'h01, 8'h22, "b2b_wr1");
        do_access(1, 1'b1, 8'h02, 8'h33, "b2b_wr2");
        sel = 1;
        @(negedge clk);
        mem_we = 1'b0; mem_addr = 8'h00; mem_req = 1'b1;
        exp_q.push_back(model_access(1, 1'b0, 8'h00, 8'h00));
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack_s !== ((i % 2) == 1) || free_s !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL b2b_pattern cycle %0d: ack=%b free=%b want %0d %0d",
                         i, ack_s, free_s, i % 2, i % 2);
            end
            if (ack_s === 1'b1) begin
                check_ack_payload("b2b_read");
                idx++;
                if (idx < 3) begin
                    mem_addr = 8'(idx);
                    exp_q.push_back(model_access(1, 1'b0, 8'(idx), 8'h00));
                end else begin
                    mem_req = 1'b0;
                end
            end
        end
        mem_req = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_out_of_range();
        do_access(2, 1'b1, 8'h00, 8'h5A, "oor_wr00");
        do_access(2, 1'b1, 8'h80, 8'hFF, "oor_wr80");
        do_access(2, 1'b0, 8'h80, 8'h00, "oor_rd80");
        do_access(2, 1'b0, 8'h00, 8'h00, "oor_rd00");
        do_access(2, 1'b1, 8'h7F, 8'hC3, "oor_wr7f");
        do_access(2, 1'b0, 8'h7F, 8'h00, "oor_rd7f");
    endtask

    task automatic test_ignore_inputs();
        int acks;
        sel = 2;
        @(negedge clk);
        mem_we = 1'b1; mem_addr = 8'h05; mem_data_i = 8'h77; mem_req = 1'b1;
        exp_q.push_back(model_access(2, 1'b1, 8'h05, 8'h77));
        @(posedge clk); #1;
        acks = 0;
        for (int j = 0; j < 10; j++) begin
            if (j < 3) begin
                mem_req    = 1'($urandom_range(0, 1));
                mem_we     = 1'($urandom_range(0, 1));
                mem_addr   = 8'($urandom_range(0, 255));
                mem_data_i = 8'($urandom_range(0, 255));
            end else begin
                mem_req = 1'b0;
            end
            @(posedge clk); #1;
            if (ack_s === 1'b1) begin
                acks++;
                checks++;
                if (j != 3) begin
                    errors++;
                    $display("FAIL ignore latency: ack at j=%0d want 3", j);
                end
                check_ack_payload("ignore_wr");
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL ignore ack_count: got %0d want 1", acks);
        end
        do_access(2, 1'b0, 8'h05, 8'h00, "ignore_rd05");
    endtask

    task automatic test_top_address();
        do_access(0, 1'b1, 8'hFF, 8'h96, "top_wr");
        do_access(0, 1'b0, 8'hFF, 8'h00, "top_rd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_access(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_ignore_inputs();
        test_top_address();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
